// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared ROB/LSQ defaults and rollback state encoding
package rob_pkg;
    localparam int ROB_DEPTH  = 16;
    localparam int ROB_PR_W   = 6;
    localparam int ROB_AR_W   = 5;
    localparam int ROB_ADDR_W = 32;
    localparam int ROB_CPL    = 2;
    localparam int ROB_RET    = 2;

    typedef enum logic {
        NORMAL   = 1'b0,
        ROLLBACK = 1'b1
    } rob_state_t;
endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrap-bit circular pointer, increment by k or decrement by one
module rob_ptr #(
    parameter int IDX_W = 4,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             dec,
    output logic [IDX_W:0]   ptr
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr <= '0;
        else      ptr <= ptr + (IDX_W+1)'(inc) - (IDX_W+1)'(dec);
    end
endmodule

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - multi-port reorder buffer with in-order retire and tail rollback
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int PR_W   = ROB_PR_W,
    parameter int AR_W   = ROB_AR_W,
    parameter int ADDR_W = ROB_ADDR_W,
    parameter int CPL    = ROB_CPL,
    parameter int RET    = ROB_RET,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  isDispatch,
    input  logic                  MemOp,
    input  logic                  RegDest,
    input  logic [PR_W-1:0]       PR_old_DP,
    input  logic [PR_W-1:0]       PR_new_DP,
    input  logic [AR_W-1:0]       rd_DP,
    input  logic                  hazard_stall,
    output logic [IDX_W-1:0]      dp_rob_num,
    input  logic [CPL-1:0]        complete,
    input  logic [CPL*IDX_W-1:0]  rob_number,
    input  logic [CPL*ADDR_W-1:0] jb_addr,
    input  logic [CPL-1:0]        changeFlow,
    output logic [RET-1:0]        retire_valid,
    output logic [RET-1:0]        retire_reg,
    output logic [RET*PR_W-1:0]   PR_old_RT,
    output logic [RET-1:0]        retire_LWST,
    output logic [RET*IDX_W-1:0]  retire_rob,
    output logic                  full,
    output logic                  empty,
    output logic [IDX_W:0]        count,
    output logic                  recover,
    output logic                  RegDest_out,
    output logic [PR_W-1:0]       PR_old_flush,
    output logic [PR_W-1:0]       PR_new_flush,
    output logic [AR_W-1:0]       rd_flush,
    output logic [IDX_W-1:0]      out_rob_num,
    output logic                  changeFlow_out,
    output logic [ADDR_W-1:0]     changeFlow_addr
);
    localparam int RC_W = $clog2(RET + 1);

    rob_state_t state_q, state_d;
    logic [IDX_W:0]   head, tail;
    logic [IDX_W-1:0] head_idx, tail_idx, last_idx, idx;
    logic [DEPTH-1:0] valid_q, done_q, cf_q;
    logic             memop_q  [DEPTH];
    logic             regdst_q [DEPTH];
    logic [PR_W-1:0]  pr_old_q [DEPTH];
    logic [PR_W-1:0]  pr_new_q [DEPTH];
    logic [AR_W-1:0]  rd_q     [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [IDX_W-1:0] cpl_idx  [CPL];
    logic             do_dp, redirect, stop;
    logic [RC_W-1:0]  n_ret;

    assign head_idx   = head[IDX_W-1:0];
    assign tail_idx   = tail[IDX_W-1:0];
    assign last_idx   = tail_idx - IDX_W'(1);
    assign count      = tail - head;
    assign full       = (count == (IDX_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign dp_rob_num = tail_idx;
    assign do_dp      = isDispatch && !full && !hazard_stall && (state_q == NORMAL);
    assign recover    = (state_q == ROLLBACK) && (tail != head);
    assign changeFlow_out = redirect;

    always_comb begin
        for (int p = 0; p < CPL; p++) cpl_idx[p] = rob_number[p*IDX_W +: IDX_W];
    end

    // A redirecting entry retires but closes the retire window behind it.
    always_comb begin
        stop            = (state_q != NORMAL);
        idx             = '0;
        n_ret           = '0;
        redirect        = 1'b0;
        changeFlow_addr = '0;
        retire_valid    = '0;
        retire_reg      = '0;
        PR_old_RT       = '0;
        retire_LWST     = '0;
        retire_rob      = '0;
        for (int i = 0; i < RET; i++) begin
            idx = head_idx + IDX_W'(i);
            if (!stop && valid_q[idx] && done_q[idx]) begin
                retire_valid[i]                = 1'b1;
                retire_reg[i]                  = regdst_q[idx];
                PR_old_RT[i*PR_W +: PR_W]      = pr_old_q[idx];
                retire_LWST[i]                 = memop_q[idx];
                retire_rob[i*IDX_W +: IDX_W]   = idx;
                n_ret                          = n_ret + RC_W'(1);
                if (cf_q[idx]) begin
                    redirect        = 1'b1;
                    changeFlow_addr = addr_q[idx];
                    stop            = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL:   if (redirect) state_d = ROLLBACK;
            ROLLBACK: if (tail == head) state_d = NORMAL;
            default:  state_d = NORMAL;
        endcase
    end

    always_comb begin
        RegDest_out  = 1'b0;
        PR_old_flush = '0;
        PR_new_flush = '0;
        rd_flush     = '0;
        out_rob_num  = '0;
        if (recover) begin
            RegDest_out  = regdst_q[last_idx];
            PR_old_flush = pr_old_q[last_idx];
            PR_new_flush = pr_new_q[last_idx];
            rd_flush     = rd_q[last_idx];
            out_rob_num  = last_idx;
        end
    end

    rob_ptr #(.IDX_W(IDX_W), .INC_W(1)) u_tail (
        .clk(clk), .rst(rst), .inc(do_dp), .dec(recover), .ptr(tail)
    );

    rob_ptr #(.IDX_W(IDX_W), .INC_W(RC_W)) u_head (
        .clk(clk), .rst(rst), .inc(n_ret), .dec(1'b0), .ptr(head)
    );

    // Ports are walked high to low so the lowest port's flow info lands last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NORMAL;
            valid_q <= '0;
            done_q  <= '0;
            cf_q    <= '0;
        end else begin
            state_q <= state_d;
            if (do_dp) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                cf_q[tail_idx]    <= 1'b0;
            end
            if (state_q == NORMAL) begin
                for (int p = CPL - 1; p >= 0; p--) begin
                    if (complete[p] && valid_q[cpl_idx[p]]) begin
                        done_q[cpl_idx[p]] <= 1'b1;
                        cf_q[cpl_idx[p]]   <= changeFlow[p];
                    end
                end
            end
            for (int i = 0; i < RET; i++) begin
                if (retire_valid[i]) valid_q[head_idx + IDX_W'(i)] <= 1'b0;
            end
            if (recover) valid_q[last_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_dp) begin
            memop_q[tail_idx]  <= MemOp;
            regdst_q[tail_idx] <= RegDest;
            pr_old_q[tail_idx] <= PR_old_DP;
            pr_new_q[tail_idx] <= PR_new_DP;
            rd_q[tail_idx]     <= rd_DP;
        end
        if (state_q == NORMAL) begin
            for (int p = CPL - 1; p >= 0; p--) begin
                if (complete[p] && valid_q[cpl_idx[p]] && changeFlow[p])
                    addr_q[cpl_idx[p]] <= jb_addr[p*ADDR_W +: ADDR_W];
            end
        end
    end
endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - scoreboard bench for rob_multiport
module tb_rob_multiport;
    localparam int PR_W = 6, AR_W = 5, ADDR_W = 32, CPL = 2, RET = 2, IDX_W = 4;

    logic clk, rst, isDispatch, MemOp, RegDest, hazard_stall;
    logic [PR_W-1:0] PR_old_DP, PR_new_DP;
    logic [AR_W-1:0] rd_DP;
    logic [IDX_W-1:0] dp_rob_num;
    logic [CPL-1:0] complete, changeFlow;
    logic [CPL*IDX_W-1:0] rob_number;
    logic [CPL*ADDR_W-1:0] jb_addr;
    logic [RET-1:0] retire_valid, retire_reg, retire_LWST;
    logic [RET*PR_W-1:0] PR_old_RT;
    logic [RET*IDX_W-1:0] retire_rob;
    logic full, empty, recover, RegDest_out, changeFlow_out;
    logic [IDX_W:0] count;
    logic [PR_W-1:0] PR_old_flush, PR_new_flush;
    logic [AR_W-1:0] rd_flush;
    logic [IDX_W-1:0] out_rob_num;
    logic [ADDR_W-1:0] changeFlow_addr;

    rob_multiport dut (
        .clk(clk), .rst(rst), .isDispatch(isDispatch), .MemOp(MemOp), .RegDest(RegDest),
        .PR_old_DP(PR_old_DP), .PR_new_DP(PR_new_DP), .rd_DP(rd_DP), .hazard_stall(hazard_stall),
        .dp_rob_num(dp_rob_num), .complete(complete), .rob_number(rob_number), .jb_addr(jb_addr),
        .changeFlow(changeFlow), .retire_valid(retire_valid), .retire_reg(retire_reg),
        .PR_old_RT(PR_old_RT), .retire_LWST(retire_LWST), .retire_rob(retire_rob),
        .full(full), .empty(empty), .count(count), .recover(recover), .RegDest_out(RegDest_out),
        .PR_old_flush(PR_old_flush), .PR_new_flush(PR_new_flush), .rd_flush(rd_flush),
        .out_rob_num(out_rob_num), .changeFlow_out(changeFlow_out), .changeFlow_addr(changeFlow_addr)
    );

    typedef struct { int rob; int pr; int slot; } ret_t;
    typedef struct { int rob; int pr_new; } fl_t;
    ret_t exp_ret[$];
    int   exp_cf[$];
    fl_t  exp_fl[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        ret_t r;
        fl_t  f;
        int   a;
        for (int k = 0; k < RET; k++) begin
            if (retire_valid[k]) begin
                if (exp_ret.size() == 0) chk("retire_unexpected", k, -1);
                else begin
                    r = exp_ret.pop_front();
                    chk("retire_rob", retire_rob[k*IDX_W +: IDX_W], r.rob);
                    chk("retire_pr_old", PR_old_RT[k*PR_W +: PR_W], r.pr);
                    chk("retire_slot", k, r.slot);
                end
            end
        end
        if (changeFlow_out) begin
            if (exp_cf.size() == 0) chk("redirect_unexpected", changeFlow_addr, -1);
            else begin
                a = exp_cf.pop_front();
                chk("redirect_addr", changeFlow_addr, a);
            end
        end
        if (recover) begin
            if (exp_fl.size() == 0) chk("flush_unexpected", out_rob_num, -1);
            else begin
                f = exp_fl.pop_front();
                chk("flush_rob", out_rob_num, f.rob);
                chk("flush_pr_new", PR_new_flush, f.pr_new);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        isDispatch = 0; complete = '0; changeFlow = '0; hazard_stall = 0;
    endtask

    task automatic disp(input int pr_old, input int pr_new);
        isDispatch = 1; PR_old_DP = PR_W'(pr_old); PR_new_DP = PR_W'(pr_new);
        rd_DP = AR_W'(pr_old); RegDest = 1; MemOp = 0;
        step();
        isDispatch = 0;
    endtask

    task automatic cpl(input int port, input int rob, input bit cf, input int addr);
        complete[port] = 1'b1;
        changeFlow[port] = cf;
        rob_number[port*IDX_W +: IDX_W] = IDX_W'(rob);
        jb_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic push_ret(input int rob, input int pr, input int slot);
        ret_t r;
        r.rob = rob; r.pr = pr; r.slot = slot;
        exp_ret.push_back(r);
    endtask

    task automatic push_fl(input int rob, input int pr_new);
        fl_t f;
        f.rob = rob; f.pr_new = pr_new;
        exp_fl.push_back(f);
    endtask

    initial begin
        rst = 0; clr(); MemOp = 0; RegDest = 0; PR_old_DP = '0; PR_new_DP = '0; rd_DP = '0;
        rob_number = '0; jb_addr = '0;
        step(); step();
        chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
        chk("rst_dp_rob_num", dp_rob_num, 0); chk("rst_retire", retire_valid, 0);
        chk("rst_recover", recover, 0); chk("rst_cf_out", changeFlow_out, 0);
        rst = 1;

        // in-order retire of out-of-order completions
        for (int i = 0; i < 4; i++) disp(i + 1, 'h21 + i);
        chk("a_count4", count, 4); chk("a_dp_rob_num", dp_rob_num, 4);
        push_ret(0, 1, 0); push_ret(1, 2, 1); push_ret(2, 3, 0); push_ret(3, 4, 0);
        cpl(0, 1, 0, 0); step(); clr();
        chk("a_hold_older", retire_valid, 0);
        cpl(0, 0, 0, 0); step(); clr();
        chk("a_ret_pair", retire_valid, 3); chk("a_count_pre", count, 4);
        cpl(0, 2, 0, 0); step(); clr();
        chk("a_ret_single", retire_valid, 1); chk("a_count2", count, 2);
        step();
        chk("a_count1", count, 1); chk("a_ret_none", retire_valid, 0);
        cpl(0, 3, 0, 0); step(); clr();
        chk("a_ret_last", retire_valid, 1);
        step();
        chk("a_empty", empty, 1);

        // full, dropped dispatch, wrap
        do_reset();
        for (int i = 0; i < 16; i++) disp('h10 + i, i);
        chk("b_full", full, 1); chk("b_count16", count, 16); chk("b_dp_wrap", dp_rob_num, 0);
        disp('h3f, 0);
        chk("b_drop_count", count, 16); chk("b_drop_dp", dp_rob_num, 0);
        push_ret(0, 'h10, 0); push_ret(1, 'h11, 1);
        cpl(0, 0, 0, 0); cpl(1, 1, 0, 0); step(); clr();
        chk("b_ret_pair", retire_valid, 3);
        disp('h3e, 0);
        chk("b_drop_on_retire", count, 14); chk("b_not_full", full, 0); chk("b_dp_still0", dp_rob_num, 0);
        disp('h3d, 0);
        chk("b_wrap_dp", dp_rob_num, 1); chk("b_count15", count, 15);

        // mispredict redirect and rollback
        do_reset();
        for (int i = 0; i < 6; i++) disp(i + 1, 'h21 + i);
        push_ret(0, 1, 0); push_ret(1, 2, 1); push_ret(2, 3, 0); push_ret(3, 4, 1);
        exp_cf.push_back('h10);
        push_fl(5, 'h26); push_fl(4, 'h25);
        cpl(0, 3, 1, 'h10); step(); clr();
        cpl(0, 0, 0, 0); cpl(1, 1, 0, 0); step(); clr();
        chk("c_ret01", retire_valid, 3); chk("c_no_cf_yet", changeFlow_out, 0);
        cpl(0, 2, 0, 0); step(); clr();
        chk("c_ret23", retire_valid, 3); chk("c_cf_out", changeFlow_out, 1);
        chk("c_cf_addr", changeFlow_addr, 'h10);
        step();
        chk("c_cf_pulse", changeFlow_out, 0); chk("c_recover5", recover, 1);
        chk("c_flush5", out_rob_num, 5); chk("c_rb_no_retire", retire_valid, 0);
        step();
        chk("c_recover4", recover, 1); chk("c_flush4", out_rob_num, 4);
        step();
        chk("c_recover_done", recover, 0); chk("c_empty", empty, 1);
        chk("c_flush_zero", PR_new_flush, 0); chk("c_tail", dp_rob_num, 4);
        step();
        disp(7, 7);
        chk("c_normal_dp", dp_rob_num, 5);

        // same-index dual completion
        do_reset();
        for (int i = 0; i < 3; i++) disp('h31 + i, i);
        push_ret(0, 'h31, 0); push_ret(1, 'h32, 1); push_ret(2, 'h33, 0);
        exp_cf.push_back('h40);
        cpl(0, 0, 0, 0); cpl(1, 1, 0, 0); step(); clr();
        cpl(0, 2, 1, 'h40); cpl(1, 2, 1, 'h80); step(); clr();
        chk("d_cf_out", changeFlow_out, 1); chk("d_cf_addr", changeFlow_addr, 'h40);
        chk("d_ret", retire_valid, 1);
        step(); step();
        chk("d_empty", empty, 1); chk("d_recover", recover, 0);

        // hazard stall, then reset mid-rollback
        do_reset();
        disp(1, 'h0a); disp(2, 'h0b);
        push_ret(0, 1, 0); push_ret(1, 2, 0);
        hazard_stall = 1; isDispatch = 1;
        cpl(1, 0, 0, 0); step(); complete = '0;
        cpl(1, 1, 0, 0); step(); complete = '0;
        chk("e_stall_retire", retire_valid, 1);
        step(); clr();
        chk("e_stall_count", count, 0); chk("e_stall_dp", dp_rob_num, 2);
        for (int k = 2; k < 6; k++) disp('h30 + k, 'h20 + k);
        push_ret(2, 'h32, 0); exp_cf.push_back('h99); push_fl(5, 'h25);
        cpl(0, 2, 1, 'h99); step(); clr();
        chk("e_cf_out", changeFlow_out, 1);
        step();
        chk("e_rb_active", recover, 1); chk("e_rb_rob", out_rob_num, 5);
        @(negedge clk); #1;
        rst = 0;
        #1;
        chk("e_rst_recover", recover, 0); chk("e_rst_empty", empty, 1); chk("e_rst_count", count, 0);
        chk("e_rst_full", full, 0); chk("e_rst_retire", retire_valid, 0);
        chk("e_rst_cf", changeFlow_out, 0); chk("e_rst_dp", dp_rob_num, 0);
        chk("e_rst_flush", PR_new_flush, 0);
        #1 rst = 1;
        disp(3, 3);
        chk("e_post_rst_dp", dp_rob_num, 1); chk("e_post_rst_count", count, 1);

        step(); step(); step();
        chk("sb_ret_drained", exp_ret.size(), 0);
        chk("sb_cf_drained", exp_cf.size(), 0);
        chk("sb_fl_drained", exp_fl.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
